store_commit_buffer: RTL

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer_if.sv | 59 +++++
 rtl/store_commit_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer_if.sv
// Signal bundle between the core pipeline and the store commit buffer.
// The core side is the master; the buffer itself is the slave.
interface store_commit_buffer_if #(
  parameter int WORD_SIZE_P    = 16,
  parameter int SB_ENTRY_P     = 8,
  parameter int COMMIT_WIDTH_P = 2
);
  localparam int IDX_W = $clog2(SB_ENTRY_P);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(COMMIT_WIDTH_P + 1);

  logic                   alloc_v_i;
  logic                   alloc_ready_o;
  logic [IDX_W-1:0]       alloc_num_o;
  logic [PTR_W-1:0]       tail_o;

  logic                   wb_v_i;
  logic [IDX_W-1:0]       wb_num_i;
  logic [WORD_SIZE_P-1:0] wb_addr_i;
  logic [WORD_SIZE_P-1:0] wb_data_i;

  logic [CNT_W-1:0]       commit_cnt_i;
  logic                   flush_i;

  logic [WORD_SIZE_P-1:0] ld_addr_i;
  logic [PTR_W-1:0]       ld_tail_i;
  logic                   ld_bypass_valid_o;
  logic [WORD_SIZE_P-1:0] ld_bypass_data_o;
  logic                   ld_stall_o;

  logic                   mem_w_v_o;
  logic [WORD_SIZE_P-1:0] mem_w_addr_o;
  logic [WORD_SIZE_P-1:0] mem_w_data_o;
  logic                   mem_w_ready_i;

  logic                   clear_v_o;
  logic [IDX_W-1:0]       clear_num_o;
  logic [SB_ENTRY_P-1:0]  wb_vector_o;
  logic [IDX_W-1:0]       commit_pt_o;
  logic [PTR_W-1:0]       count_o;

  modport master (
    output alloc_v_i, wb_v_i, wb_num_i, wb_addr_i, wb_data_i,
           commit_cnt_i, flush_i, ld_addr_i, ld_tail_i, mem_w_ready_i,
    input  alloc_ready_o, alloc_num_o, tail_o, ld_bypass_valid_o,
           ld_bypass_data_o, ld_stall_o, mem_w_v_o, mem_w_addr_o,
           mem_w_data_o, clear_v_o, clear_num_o, wb_vector_o,
           commit_pt_o, count_o
  );

  modport slave (
    input  alloc_v_i, wb_v_i, wb_num_i, wb_addr_i, wb_data_i,
           commit_cnt_i, flush_i, ld_addr_i, ld_tail_i, mem_w_ready_i,
    output alloc_ready_o, alloc_num_o, tail_o, ld_bypass_valid_o,
           ld_bypass_data_o, ld_stall_o, mem_w_v_o, mem_w_addr_o,
           mem_w_data_o, clear_v_o, clear_num_o, wb_vector_o,
           commit_pt_o, count_o
  );
endinterface

// File: rtl/store_commit_buffer.sv
// Circular store buffer: allocate in order, write back out of order, commit
// oldest-first, drain one committed store per cycle, forward to younger loads.
//
// Drain FSM
//   state | meaning
//   IDLE  | no store presented to memory; waits for the head entry to commit
//   BUSY  | mem_w_* holds the head store until mem_w_ready_i
module store_commit_buffer #(
  parameter int WORD_SIZE_P    = 16,
  parameter int SB_ENTRY_P     = 8,
  parameter int COMMIT_WIDTH_P = 2
) (
  input logic              clk_i,
  input logic              reset_i,
  store_commit_buffer_if.slave sb
);
  localparam int IDX_W = $clog2(SB_ENTRY_P);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(COMMIT_WIDTH_P + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, cmt_q, tail_q;
  logic [SB_ENTRY_P-1:0]  valid_q, written_q, committed_q;
  logic [WORD_SIZE_P-1:0] addr_q [SB_ENTRY_P];
  logic [WORD_SIZE_P-1:0] data_q [SB_ENTRY_P];
  logic [WORD_SIZE_P-1:0] mem_addr_q, mem_data_q;
  logic                   clear_v_q;
  logic [IDX_W-1:0]       clear_num_q;

  logic [PTR_W-1:0]       count, cmt_next, head_inc;
  logic [IDX_W-1:0]       head_idx, next_idx, tail_idx, load_idx;
  logic                   full, alloc_ready, alloc_fire, wb_ok;
  logic                   load_en, drain_done;
  logic [SB_ENTRY_P-1:0]  alloc_vec, wb_vec, free_vec, new_cmt, flush_kill;

  assign count       = tail_q - head_q;
  assign full        = (count == PTR_W'(SB_ENTRY_P));
  assign alloc_ready = !full && !sb.flush_i;
  assign alloc_fire  = sb.alloc_v_i && alloc_ready;
  assign cmt_next    = cmt_q + PTR_W'(sb.commit_cnt_i);
  assign head_inc    = head_q + PTR_W'(1);
  assign head_idx    = head_q[IDX_W-1:0];
  assign next_idx    = head_inc[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign wb_ok       = sb.wb_v_i && valid_q[sb.wb_num_i] && !committed_q[sb.wb_num_i];

  assign alloc_vec = alloc_fire ? (SB_ENTRY_P'(1) << tail_idx) : '0;
  assign wb_vec    = wb_ok ? (SB_ENTRY_P'(1) << sb.wb_num_i) : '0;
  assign free_vec  = drain_done ? (SB_ENTRY_P'(1) << head_idx) : '0;

  // Entries the commit port retires this cycle, starting at the commit pointer
  always_comb begin
    logic [PTR_W-1:0] p;
    new_cmt = '0;
    p       = '0;
    for (int j = 0; j < COMMIT_WIDTH_P; j++) begin
      p = cmt_q + PTR_W'(j);
      if (CNT_W'(j) < sb.commit_cnt_i) new_cmt[p[IDX_W-1:0]] = 1'b1;
    end
  end

  // Commit is applied before flush, so freshly committed stores survive it
  assign flush_kill = sb.flush_i ? (valid_q & ~committed_q & ~new_cmt) : '0;

  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    load_idx   = head_idx;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_q[head_idx] && committed_q[head_idx]) begin
          load_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (sb.mem_w_ready_i) begin
          drain_done = 1'b1;
          if (valid_q[next_idx] && committed_q[next_idx]) begin
            load_en  = 1'b1;
            load_idx = next_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      written_q   <= '0;
      committed_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      clear_v_q   <= 1'b0;
      clear_num_q <= '0;
    end else begin
      state_q     <= state_d;
      cmt_q       <= cmt_next;
      clear_v_q   <= drain_done;
      clear_num_q <= drain_done ? head_idx : '0;
      if (sb.flush_i)      tail_q <= cmt_next;
      else if (alloc_fire) tail_q <= tail_q + PTR_W'(1);
      if (drain_done) head_q <= head_inc;
      valid_q     <= (valid_q | alloc_vec) & ~flush_kill & ~free_vec;
      written_q   <= ((written_q & ~alloc_vec) | wb_vec) & ~flush_kill & ~free_vec;
      committed_q <= ((committed_q & ~alloc_vec) | new_cmt) & ~free_vec;
      if (load_en) begin
        mem_addr_q <= addr_q[load_idx];
        mem_data_q <= data_q[load_idx];
      end
    end
  end

  // Payload storage needs no reset: it is only read behind valid/written
  always_ff @(posedge clk_i) begin
    if (wb_ok) begin
      addr_q[sb.wb_num_i] <= sb.wb_addr_i;
      data_q[sb.wb_num_i] <= sb.wb_data_i;
    end
  end

  // Forwarding scan from oldest to youngest over [head, ld_tail); an unwritten
  // entry younger than the latest match makes the result unknown
  logic                   byp_hit, byp_stall;
  logic [WORD_SIZE_P-1:0] byp_data;
  always_comb begin
    logic [PTR_W-1:0] span, ptr;
    logic [IDX_W-1:0] idx;
    byp_hit   = 1'b0;
    byp_stall = 1'b0;
    byp_data  = '0;
    span      = sb.ld_tail_i - head_q;
    ptr       = '0;
    idx       = '0;
    for (int i = 0; i < SB_ENTRY_P; i++) begin
      ptr = head_q + PTR_W'(i);
      idx = ptr[IDX_W-1:0];
      if (PTR_W'(i) < span && valid_q[idx]) begin
        if (!written_q[idx]) begin
          byp_stall = 1'b1;
        end else if (addr_q[idx] == sb.ld_addr_i) begin
          byp_hit   = 1'b1;
          byp_stall = 1'b0;
          byp_data  = data_q[idx];
        end
      end
    end
  end

  assign sb.alloc_ready_o     = alloc_ready;
  assign sb.alloc_num_o       = tail_idx;
  assign sb.tail_o            = tail_q;
  assign sb.count_o           = count;
  assign sb.commit_pt_o       = cmt_q[IDX_W-1:0];
  assign sb.wb_vector_o       = written_q;
  assign sb.ld_bypass_valid_o = byp_hit && !byp_stall;
  assign sb.ld_bypass_data_o  = (byp_hit && !byp_stall) ? byp_data : '0;
  assign sb.ld_stall_o        = byp_stall;
  assign sb.mem_w_v_o         = (state_q == BUSY);
  assign sb.mem_w_addr_o      = mem_addr_q;
  assign sb.mem_w_data_o      = mem_data_q;
  assign sb.clear_v_o         = clear_v_q;
  assign sb.clear_num_o       = clear_num_q;
endmodule
